// File: rtl/test_pattern_checker_if.sv
// Recovered bit stream from the data-recovery stage into the PRBS-7 checker.
interface test_pattern_checker_if;
  logic bit_in;
  logic bit_valid;

  modport master (output bit_in, output bit_valid);
  modport slave  (input  bit_in, input  bit_valid);
endinterface

// File: rtl/test_pattern_checker.sv
// PRBS-7 (x^7 + x^6 + 1) receive checker: self-synchronizes, locks, counts bits and errors.
// Optional TEST_PATTERN_CHK_ERR_INJECT_EN adds an inject_err port that inverts the next valid bit.
module test_pattern_checker #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LOCK_BITS   = 64,
  parameter int unsigned UNLOCK_ERRS = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  test_pattern_checker_if.slave  rx,
`ifdef TEST_PATTERN_CHK_ERR_INJECT_EN
  input  logic                   inject_err,
`endif
  input  logic                   clear,
  output logic                   locked,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       bit_count,
  output logic                   lock_lost
);

  localparam logic [1:0] StSeed   = 2'd0;
  localparam logic [1:0] StAcq    = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [7:0] LockM   = 8'(LOCK_BITS);
  localparam logic [7:0] UnlockE = 8'(UNLOCK_ERRS);

  logic [1:0]       state_q, state_d;
  logic [6:0]       r_q, r_d;
  logic [2:0]       seed_q, seed_d;
  logic [7:0]       m_q, m_d;
  logic [6:0]       w_q, w_d;
  logic [7:0]       e_q, e_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             lock_lost_q, lock_lost_d;

  logic line_bit;
  logic pred;
  logic mismatch;

`ifdef TEST_PATTERN_CHK_ERR_INJECT_EN
  logic inj_q, inj_d;

  // A pulse coincident with a valid bit arms the flag for the following bit.
  always_comb begin
    inj_d = inj_q;
    if (rx.bit_valid) inj_d = 1'b0;
    if (inject_err)   inj_d = 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) inj_q <= 1'b0;
    else          inj_q <= inj_d;
  end

  assign line_bit = rx.bit_in ^ inj_q;
`else
  assign line_bit = rx.bit_in;
`endif

  assign pred     = r_q[6] ^ r_q[5];
  assign mismatch = line_bit ^ pred;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    seed_d      = seed_q;
    m_d         = m_q;
    w_d         = w_q;
    e_d         = e_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    // A loss of lock in the same cycle as clear still sets the sticky flag.
    lock_lost_d = lock_lost_q & ~clear;

    if (rx.bit_valid) begin
      unique case (state_q)
        StSeed: begin
          r_d = {r_q[5:0], line_bit};
          if (seed_q == 3'd6) begin
            seed_d  = 3'd0;
            m_d     = 8'd0;
            state_d = StAcq;
          end else begin
            seed_d = seed_q + 3'd1;
          end
        end
        StAcq: begin
          r_d = {r_q[5:0], line_bit};
          // An all-zero register predicts zero forever; never let that count toward lock.
          if (mismatch || (r_d == 7'd0)) m_d = 8'd0;
          else                           m_d = m_q + 8'd1;
          if (m_d == LockM) begin
            state_d = StLocked;
            w_d     = 7'd0;
            e_d     = 8'd0;
          end
        end
        StLocked: begin
          // Free-running prediction so one line error costs exactly one counted error.
          r_d = {r_q[5:0], pred};
          w_d = w_q + 7'd1;
          if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
          end
          if (w_q == 7'd127) e_d = {7'd0, mismatch};
          else               e_d = e_q + {7'd0, mismatch};
          if (e_d == UnlockE) begin
            state_d     = StSeed;
            seed_d      = 3'd0;
            lock_lost_d = 1'b1;
          end
        end
        default: begin
          state_d = StSeed;
          seed_d  = 3'd0;
        end
      endcase
    end

    if (clear) begin
      err_count_d = '0;
      bit_count_d = '0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StSeed;
      r_q         <= 7'd0;
      seed_q      <= 3'd0;
      m_q         <= 8'd0;
      w_q         <= 7'd0;
      e_q         <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      seed_q      <= seed_d;
      m_q         <= m_d;
      w_q         <= w_d;
      e_q         <= e_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
  assign lock_lost = lock_lost_q;

endmodule
